// File: rtl/circular_ptr_slots_retire_tracker_pkg.sv
// Shared widths and status bundle for the circular slot retire tracker.
// Width helpers are functions so any parameterisation can reuse them.
package circular_ptr_slots_retire_tracker_pkg;

    // Status fields are carried at a fixed generous width; the top
    // narrows them onto its ports. Supports rings up to 2**15 slots.
    localparam int STATUS_W = 16;

    function automatic int ptr_width(input int slots);
        return (slots > 1) ? $clog2(slots) : 1;
    endfunction

    function automatic int count_width(input int slots);
        return $clog2(slots + 1);
    endfunction

    function automatic int add_width(input int max_add);
        return $clog2(max_add + 1);
    endfunction

    function automatic int retire_width(input int max_retire);
        return $clog2(max_retire + 1);
    endfunction

    typedef struct packed {
        logic [STATUS_W-1:0] count;
        logic [STATUS_W-1:0] free;
        logic                empty;
        logic                full;
    } tracker_status_t;

endpackage

// File: rtl/circular_ptr_slots_retire_tracker_mod_add.sv
// circular_ptr_mod_add: ptr_o = (ptr_i + inc_i) mod slots_p.
// Ports: ptr_i (current pointer), inc_i (increment <= slots_p), ptr_o.
module circular_ptr_mod_add
    import circular_ptr_slots_retire_tracker_pkg::*;
#(
    parameter int slots_p     = 32,
    parameter int inc_width_p = 5
) (
    input  logic [ptr_width(slots_p)-1:0] ptr_i,
    input  logic [inc_width_p-1:0]        inc_i,
    output logic [ptr_width(slots_p)-1:0] ptr_o
);

    localparam int PW = ptr_width(slots_p);
    localparam logic [PW:0] SLOTS = (PW+1)'(slots_p);

    logic [PW:0] sum;

    // ptr < slots and inc <= slots, so one conditional subtract is exact
    assign sum = {1'b0, ptr_i} + (PW+1)'(inc_i);

    always_comb begin
        ptr_o = PW'((sum >= SLOTS) ? (sum - SLOTS) : sum);
    end

endmodule

// File: rtl/circular_ptr_slots_retire_tracker.sv
// Tail/head/occupancy tracker for a ring of slots_p entries with
// multi-slot allocate and retire under valid/yumi handshakes.
// Ports: clk, reset_i (async, active-high); alloc_v_i/alloc_n_i ->
// alloc_yumi_o, alloc_ptr_o (tail); retire_v_i/retire_n_i ->
// retire_yumi_o, retire_ptr_o (head); count_o, free_o, empty_o, full_o.
// Optional CIRC_PTR_RETIRE_HWM_EN adds hwm_clr_i and hwm_o
// (high-water mark of occupancy).
module circular_ptr_slots_retire_tracker
    import circular_ptr_slots_retire_tracker_pkg::*;
#(
    parameter int slots_p      = 32,
    parameter int max_add_p    = 31,
    parameter int max_retire_p = 31
) (
    input  logic                                clk,
    input  logic                                reset_i,
    input  logic                                alloc_v_i,
    input  logic [add_width(max_add_p)-1:0]     alloc_n_i,
    output logic                                alloc_yumi_o,
    output logic [ptr_width(slots_p)-1:0]       alloc_ptr_o,
    input  logic                                retire_v_i,
    input  logic [retire_width(max_retire_p)-1:0] retire_n_i,
    output logic                                retire_yumi_o,
    output logic [ptr_width(slots_p)-1:0]       retire_ptr_o,
    output logic [count_width(slots_p)-1:0]     count_o,
    output logic [count_width(slots_p)-1:0]     free_o,
    output logic                                empty_o,
    output logic                                full_o
`ifdef CIRC_PTR_RETIRE_HWM_EN
    ,
    input  logic                                hwm_clr_i,
    output logic [count_width(slots_p)-1:0]     hwm_o
`endif
);

    localparam int PW = ptr_width(slots_p);
    localparam int CW = count_width(slots_p);
    localparam int AW = add_width(max_add_p);
    localparam int RW = retire_width(max_retire_p);
    localparam logic [STATUS_W-1:0] SLOTS = STATUS_W'(slots_p);

    logic [PW-1:0]   tail_q, tail_d;
    logic [PW-1:0]   head_q, head_d;
    tracker_status_t st_q, st_d;
    logic [AW-1:0]   add_n;
    logic [RW-1:0]   ret_n;

    // Both checks use start-of-cycle state only, so the two ports
    // never see each other's same-cycle effect.
    assign alloc_yumi_o  = alloc_v_i & ~reset_i
                         & (STATUS_W'(alloc_n_i) <= st_q.free);
    assign retire_yumi_o = retire_v_i & ~reset_i
                         & (STATUS_W'(retire_n_i) <= st_q.count);

    assign add_n = alloc_yumi_o  ? alloc_n_i  : '0;
    assign ret_n = retire_yumi_o ? retire_n_i : '0;

    circular_ptr_mod_add #(
        .slots_p     (slots_p),
        .inc_width_p (AW)
    ) u_tail_add (
        .ptr_i (tail_q),
        .inc_i (add_n),
        .ptr_o (tail_d)
    );

    circular_ptr_mod_add #(
        .slots_p     (slots_p),
        .inc_width_p (RW)
    ) u_head_add (
        .ptr_i (head_q),
        .inc_i (ret_n),
        .ptr_o (head_d)
    );

    always_comb begin
        st_d       = st_q;
        st_d.count = st_q.count + STATUS_W'(add_n) - STATUS_W'(ret_n);
        st_d.free  = SLOTS - st_d.count;
        st_d.empty = (st_d.count == '0);
        st_d.full  = (st_d.count == SLOTS);
    end

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            tail_q     <= '0;
            head_q     <= '0;
            st_q.count <= '0;
            st_q.free  <= SLOTS;
            st_q.empty <= 1'b1;
            st_q.full  <= 1'b0;
        end else begin
            tail_q <= tail_d;
            head_q <= head_d;
            st_q   <= st_d;
        end
    end

    assign alloc_ptr_o  = tail_q;
    assign retire_ptr_o = head_q;
    assign count_o      = CW'(st_q.count);
    assign free_o       = CW'(st_q.free);
    assign empty_o      = st_q.empty;
    assign full_o       = st_q.full;

`ifdef CIRC_PTR_RETIRE_HWM_EN
    logic [CW-1:0] hwm_q, hwm_d, cnt_nxt;

    assign cnt_nxt = CW'(st_d.count);

    // Clear reloads the current occupancy so the mark stays meaningful
    always_comb begin
        hwm_d = hwm_q;
        if (hwm_clr_i) begin
            hwm_d = cnt_nxt;
        end else if (cnt_nxt > hwm_q) begin
            hwm_d = cnt_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            hwm_q <= '0;
        end else begin
            hwm_q <= hwm_d;
        end
    end

    assign hwm_o = hwm_q;
`endif

endmodule

// File: tb/tb_circular_ptr_slots_retire_tracker.sv
// Directed bench for circular_ptr_slots_retire_tracker: a 32-slot
// instance and a 24-slot instance for non-power-of-two wrap.
module tb_circular_ptr_slots_retire_tracker;

    logic clk;
    logic rst;

    logic       a32_v, r32_v, a32_y, r32_y;
    logic [4:0] a32_n, r32_n;
    logic [4:0] t32, h32;
    logic [5:0] c32, f32;
    logic       e32, u32_full;

    logic       a24_v, r24_v, a24_y, r24_y;
    logic [3:0] a24_n, r24_n;
    logic [4:0] t24, h24;
    logic [4:0] c24, f24;
    logic       e24, u24_full;

    logic       hclr32, hclr24;
    logic [5:0] hwm32;
    logic [4:0] hwm24;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    circular_ptr_slots_retire_tracker #(
        .slots_p(32), .max_add_p(31), .max_retire_p(31)
    ) u32 (
        .clk(clk), .reset_i(rst),
        .alloc_v_i(a32_v), .alloc_n_i(a32_n), .alloc_yumi_o(a32_y),
        .alloc_ptr_o(t32),
        .retire_v_i(r32_v), .retire_n_i(r32_n), .retire_yumi_o(r32_y),
        .retire_ptr_o(h32),
        .count_o(c32), .free_o(f32), .empty_o(e32), .full_o(u32_full)
`ifdef CIRC_PTR_RETIRE_HWM_EN
        , .hwm_clr_i(hclr32), .hwm_o(hwm32)
`endif
    );

    circular_ptr_slots_retire_tracker #(
        .slots_p(24), .max_add_p(8), .max_retire_p(8)
    ) u24 (
        .clk(clk), .reset_i(rst),
        .alloc_v_i(a24_v), .alloc_n_i(a24_n), .alloc_yumi_o(a24_y),
        .alloc_ptr_o(t24),
        .retire_v_i(r24_v), .retire_n_i(r24_n), .retire_yumi_o(r24_y),
        .retire_ptr_o(h24),
        .count_o(c24), .free_o(f24), .empty_o(e24), .full_o(u24_full)
`ifdef CIRC_PTR_RETIRE_HWM_EN
        , .hwm_clr_i(hclr24), .hwm_o(hwm24)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Ring invariant: (tail - head) mod slots == count mod slots
    always @(negedge clk) begin
        chk("inv32", 32'((int'(t32) - int'(h32) + 32) % 32),
            32'(int'(c32) % 32));
        chk("inv24", 32'((int'(t24) - int'(h24) + 24) % 24),
            32'(int'(c24) % 24));
    end

    task automatic cyc32(input bit av, input int an, input bit rv,
                         input int rn, input bit eay, input bit ery,
                         input string tag);
        @(negedge clk);
        a32_v = av; a32_n = 5'(an);
        r32_v = rv; r32_n = 5'(rn);
        #1;
        chk({tag, ".ay"}, 32'(a32_y), 32'(eay));
        chk({tag, ".ry"}, 32'(r32_y), 32'(ery));
        @(posedge clk);
        #1;
        a32_v = 1'b0; r32_v = 1'b0; hclr32 = 1'b0;
    endtask

    task automatic st32(input string tag, input int tp, input int hp,
                        input int cnt, input bit emp, input bit ful);
        chk({tag, ".tail"},  32'(t32), 32'(tp));
        chk({tag, ".head"},  32'(h32), 32'(hp));
        chk({tag, ".count"}, 32'(c32), 32'(cnt));
        chk({tag, ".free"},  32'(f32), 32'(32 - cnt));
        chk({tag, ".empty"}, 32'(e32), 32'(emp));
        chk({tag, ".full"},  32'(u32_full), 32'(ful));
    endtask

    task automatic cyc24(input bit av, input int an, input bit rv,
                         input int rn, input bit eay, input bit ery,
                         input string tag);
        @(negedge clk);
        a24_v = av; a24_n = 4'(an);
        r24_v = rv; r24_n = 4'(rn);
        #1;
        chk({tag, ".ay"}, 32'(a24_y), 32'(eay));
        chk({tag, ".ry"}, 32'(r24_y), 32'(ery));
        @(posedge clk);
        #1;
        a24_v = 1'b0; r24_v = 1'b0;
    endtask

    task automatic st24(input string tag, input int tp, input int hp,
                        input int cnt);
        chk({tag, ".tail"},  32'(t24), 32'(tp));
        chk({tag, ".head"},  32'(h24), 32'(hp));
        chk({tag, ".count"}, 32'(c24), 32'(cnt));
        chk({tag, ".free"},  32'(f24), 32'(24 - cnt));
        chk({tag, ".empty"}, 32'(e24), 32'(cnt == 0));
    endtask

    initial begin
        rst = 1'b1;
        a32_v = 0; a32_n = 0; r32_v = 0; r32_n = 0;
        a24_v = 0; a24_n = 0; r24_v = 0; r24_n = 0;
        hclr32 = 0; hclr24 = 0;
        #1;
        st32("rst", 0, 0, 0, 1, 0);
        st24("rst24", 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;

        // Accept some work, then pulse reset asynchronously mid-cycle
        cyc32(1, 5, 0, 0, 1, 0, "a5");
        st32("a5", 5, 0, 5, 0, 0);
        a32_v = 1'b1; a32_n = 5'd5;
        #2 rst = 1'b1;
        #1;
        st32("arst", 0, 0, 0, 1, 0);
        chk("arst.ay", 32'(a32_y), 32'd0);
        @(negedge clk);
        rst = 1'b0; a32_v = 1'b0;
        @(posedge clk); #1;
        st32("arst2", 0, 0, 0, 1, 0);

        // Fill to full
        cyc32(1, 31, 0, 0, 1, 0, "f31");
        st32("f31", 31, 0, 31, 0, 0);
        cyc32(1, 1, 0, 0, 1, 0, "f1");
        st32("f1", 0, 0, 32, 0, 1);
        cyc32(1, 1, 0, 0, 0, 0, "ovf");
        cyc32(1, 0, 0, 0, 1, 0, "n0");
        st32("n0", 0, 0, 32, 0, 1);

        // Over-retire
        cyc32(0, 0, 1, 29, 0, 1, "r29");
        st32("r29", 0, 29, 3, 0, 0);
        cyc32(0, 0, 1, 4, 0, 0, "r4");
        st32("r4", 0, 29, 3, 0, 0);
        cyc32(0, 0, 1, 3, 0, 1, "r3");
        st32("r3", 0, 0, 0, 1, 0);
        cyc32(0, 0, 1, 1, 0, 0, "unf");
        cyc32(0, 0, 1, 0, 0, 1, "rn0");
        st32("rn0", 0, 0, 0, 1, 0);

        // Simultaneous alloc/retire
        cyc32(1, 30, 0, 0, 1, 0, "a30");
        st32("a30", 30, 0, 30, 0, 0);
        cyc32(1, 5, 1, 10, 0, 1, "sim1");
        st32("sim1", 30, 10, 20, 0, 0);
        cyc32(1, 13, 1, 5, 0, 1, "sim2");
        st32("sim2", 30, 15, 15, 0, 0);
        cyc32(1, 17, 1, 15, 1, 1, "sim3");
        st32("sim3", 15, 30, 17, 0, 0);

        // Non-power-of-two wrap on the 24-slot ring
        cyc24(1, 8, 0, 0, 1, 0, "w8a");
        cyc24(1, 8, 0, 0, 1, 0, "w8b");
        cyc24(1, 4, 0, 0, 1, 0, "w4");
        st24("w20", 20, 0, 20);
        cyc24(0, 0, 1, 8, 0, 1, "x8a");
        cyc24(0, 0, 1, 8, 0, 1, "x8b");
        cyc24(0, 0, 1, 4, 0, 1, "x4");
        st24("x20", 20, 20, 0);
        cyc24(1, 6, 0, 0, 1, 0, "wrap6");
        st24("wrap6", 2, 20, 6);
        cyc24(0, 0, 1, 2, 0, 1, "x2");
        st24("x2", 2, 22, 4);
        cyc24(0, 0, 1, 4, 0, 1, "hwrap");
        st24("hwrap", 2, 2, 0);

        // Mid-op reset and high-water mark
        @(negedge clk);
        rst = 1'b1;
        #1;
        st32("rst3", 0, 0, 0, 1, 0);
        @(negedge clk);
        rst = 1'b0;
        cyc32(1, 17, 0, 0, 1, 0, "h17");
        st32("h17", 17, 0, 17, 0, 0);
`ifdef CIRC_PTR_RETIRE_HWM_EN
        chk("hwm17", 32'(hwm32), 32'd17);
`endif
        cyc32(0, 0, 1, 8, 0, 1, "h9");
        st32("h9", 17, 8, 9, 0, 0);
`ifdef CIRC_PTR_RETIRE_HWM_EN
        chk("hwm17b", 32'(hwm32), 32'd17);
        hclr32 = 1'b1;
`endif
        cyc32(0, 0, 0, 0, 0, 0, "hclr");
`ifdef CIRC_PTR_RETIRE_HWM_EN
        chk("hwmclr", 32'(hwm32), 32'd9);
`endif
        cyc32(1, 2, 0, 0, 1, 0, "h11");
        st32("h11", 19, 8, 11, 0, 0);
`ifdef CIRC_PTR_RETIRE_HWM_EN
        chk("hwm11", 32'(hwm32), 32'd11);
`endif
        @(negedge clk);
        rst = 1'b1;
        #1;
        st32("rst4", 0, 0, 0, 1, 0);
`ifdef CIRC_PTR_RETIRE_HWM_EN
        chk("hwmrst", 32'(hwm32), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/circular_ptr_slots_retire_tracker.md
Name: circular_ptr_slots_retire_tracker

Overview:
- Consumer-side companion to the circular add-pointer that allocates slots in a ring of slots_p entries.
- Tracks three quantities: the allocation (tail) pointer, the retire (head) pointer, and occupancy.
- Accepts multi-slot allocate and retire requests under a valid/yumi handshake, so a ring buffer can never be overrun or underrun.
- Sits between a multi-issue producer (e.g. an LSU or ROB-style allocator) and its in-order retire logic.

Parameters:
- slots_p, 32: ring depth. Any value ≥2; not required to be a power of two.
- max_add_p, 31: maximum slots allocated in one cycle. Must be ≤slots_p.
- max_retire_p, 31: maximum slots retired in one cycle. Must be ≤slots_p.

Ports:
- clk  in  1  clock.
- reset_i  in  1  asynchronous reset, active-high.
- alloc_v_i  in  1  allocate request valid.
- alloc_n_i  in  clog2(max_add_p+1)  number of slots requested.
- alloc_yumi_o  out  1  allocate request accepted this cycle.
- alloc_ptr_o  out  clog2(slots_p)  current tail; first slot granted on acceptance.
- retire_v_i  in  1  retire request valid.
- retire_n_i  in  clog2(max_retire_p+1)  number of slots to retire.
- retire_yumi_o  out  1  retire request accepted this cycle.
- retire_ptr_o  out  clog2(slots_p)  current head; oldest occupied slot.
- count_o  out  clog2(slots_p+1)  occupied slots.
- free_o  out  clog2(slots_p+1)  free slots, equal to slots_p − count.
- empty_o  out  1  count==0.
- full_o  out  1  count==slots_p.

Behaviour:
- Reset:
  - The interface is fixed: one clock; reset is asynchronous and active-high.
  - While reset_i is high, all registers clear immediately: tail=0, head=0, count=0.
  - Resulting outputs: alloc_ptr_o=0, retire_ptr_o=0, count_o=0, free_o=slots_p, empty_o=1, full_o=0.
  - Yumis are forced to 0 while reset_i is high.
  - Reset asserted mid-operation discards all state. No partial update survives.
- Handshake (yumis are combinational, no state change beyond the clock edge):
  - alloc_yumi_o = alloc_v_i & (alloc_n_i ≤ free_r).
  - retire_yumi_o = retire_v_i & (retire_n_i ≤ count_r).
  - Both checks use registered start-of-cycle values. A same-cycle retire does NOT free space for a same-cycle alloc, and a same-cycle alloc is NOT retirable in the same cycle.
  - No valid-to-yumi path depends on the other port.
  - A rejected request has no effect. The requester holds or changes it freely.
- Update at the clock edge:
  - tail_n = (tail + a) mod slots_p, where a = alloc_yumi ? alloc_n_i : 0.
  - head_n = (head + r) mod slots_p, where r = retire_yumi ? retire_n_i : 0.
  - count_n = count + a − r.
  - Modulo is implemented as a sum at width clog2(slots_p)+1 followed by a conditional subtract of slots_p. Exact for any slots_p, since each addend is <slots_p+1.
  - Outputs are registered values. Pointer and count changes are visible one cycle after acceptance.
- Boundary cases:
  - n=0 with valid=1: accepted (yumi=1), no state change.
  - Full with alloc_n_i>0: rejected. Empty with retire_n_i>0: rejected.
  - Alloc of exactly free_r slots: accepted, full_o=1 next cycle.
  - Simultaneous alloc and retire: both may be accepted, net count change a−r.
  - Wrap-around: with slots_p non-power-of-two (e.g. 24), tail 20 + 6 gives 2.
  - Invariant: (tail − head) mod slots_p == count mod slots_p. count distinguishes full from empty when tail==head.

Optional Feature:
- Macro: CIRC_PTR_RETIRE_HWM_EN.
- When defined:
  - Extra output hwm_o, width clog2(slots_p+1): high-water mark of count.
  - Extra input hwm_clr_i, width 1.
  - Update rule: hwm ← max(hwm, count_n) each cycle.
  - hwm_clr_i loads count_n instead of the max.
  - Reset value 0.
- When undefined: these ports and this logic do not exist. All other behaviour is identical.

Decomposition:
- Shared package holds:
  - Width constants (ptr_width, count_width, add_width, retire_width) as functions of the parameters.
  - A typedef for the tracker status struct {count, free, empty, full}.
- One natural sub-module: circular_ptr_mod_add. It takes ptr, inc, and slots_p and returns (ptr+inc) mod slots_p. It is instantiated twice, for head and tail.
- Count and flag logic stay in the top module.

Test Plan:
- Reset then idle: with reset_i pulsed asynchronously mid-cycle, all outputs clear immediately: ptrs 0, count 0, free 32, empty 1.
- Fill: alloc_n=31 then alloc_n=1 → alloc_ptr_o goes 0→31→0, count 32, full_o=1. A further alloc_n=1 gives yumi=0.
- Over-retire: count=3, retire_n=4 → yumi=0, no change. Then retire_n=3 → head+3, empty_o=1.
- Simultaneous: count=30, alloc_n=5 (free 2) with retire_n=10 → alloc rejected, retire accepted, count 20.
- Non-pow2 wrap (slots_p=24): tail=20, alloc_n=6 → tail=2. head=22, retire_n=4 → head=2. Invariant checked every cycle.
- Mid-op reset plus HWM (macro defined): count peaks at 17 → hwm_o=17. hwm_clr_i with count 9 → hwm_o=9. Asserting reset_i → hwm_o=0 and all state cleared.
